// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences a 1-bit add cell LSB-first over WIDTH bits.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a-b via ~b and carry preset to 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sub_sel;
  logic             bit_s, bit_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // The single add cell: two half adders plus the carry flop.
  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = sub_sel ? ~b : b;
          carry_d = sub_sel;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = bit_c;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        // Hold the counter on the last bit so it never wraps.
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cout_d  = bit_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 directed/random/corner cases
// plus an exhaustive WIDTH=2 instance.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       sub_s;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2;
  logic [1:0] a2, b2;
  logic       sub2_s;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int checks   = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2_s),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    logic [8:0] r;
    if (sv) begin
      r[7:0] = av - bv;
      r[8]   = (av >= bv);
    end else begin
      r = {1'b0, av} + {1'b0, bv};
    end
    return r;
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input logic [7:0] es, input logic ec, input string tag);
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    a = av; b = bv; sub_s = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av;  // operand changes after acceptance must not matter
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " busy_window"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " done_busy"}, {30'd0, done, busy}, 32'd2);
    check({tag, " sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
    $display("op %s a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d (exp %02h/%0d)",
             tag, av, bv, sv, sum, cout, es, ec);
    @(negedge clk);
    check({tag, " done_width"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op2(input logic [1:0] av, input logic [1:0] bv);
    logic [2:0] exp;
    bit lat_ok;
    exp = {1'b0, av} + {1'b0, bv};
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    @(negedge clk);            // after accepting edge
    start2 = 1'b0;
    lat_ok = (done2 === 1'b0);
    @(negedge clk);            // after 1st bit edge
    lat_ok = lat_ok && (done2 === 1'b0);
    @(negedge clk);            // after 2nd bit edge: done visible
    lat_ok = lat_ok && (done2 === 1'b1);
    check("w2 latency", {31'd0, lat_ok}, 32'd1);
    check("w2 result", {29'd0, cout2, sum2}, {29'd0, exp});
    $display("op w2 a=%0d b=%0d -> cout,sum=%0d (exp %0d)", av, bv, {cout2, sum2}, exp);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[$];
    int   done_cycles[$];
    bit   hold_ok;
    int   late_dones;
    logic [7:0] ra, rb;
    logic       rs;
    logic [8:0] rexp;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_s = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; sub2_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {22'd0, busy, done, cout, sum}, 32'd0);
    check("reset outputs w2", {28'd0, busy2, done2, cout2, sum2}, 32'd0);
    rst_n = 1'b1;

    tbl.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));

    hold_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sum !== 8'hFF || busy !== 1'b0 || done !== 1'b0) hold_ok = 1'b0;
    end
    check("idle hold", {31'd0, hold_ok}, 32'd1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub1");
    run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "sub2");
`endif

    // Start held high: one op every 10 cycles; a mid-RUN change is ignored.
    @(negedge clk);
    a = 8'h03; b = 8'h04; sub_s = 1'b0; start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c == 3) a = 8'h80;
      if (c == 6) a = 8'h03;
      if (done === 1'b1) begin
        done_cycles.push_back(c);
        check($sformatf("held sum c%0d", c), {24'd0, sum}, 32'h07);
        $display("op held done at cycle %0d sum=%02h cout=%0d", c, sum, cout);
      end
    end
    start = 1'b0;
    check("held done count", done_cycles.size(), 32'd3);
    if (done_cycles.size() == 3) begin
      check("held first done", done_cycles[0], 32'd9);
      check("held interval1", done_cycles[1] - done_cycles[0], 32'd10);
      check("held interval2", done_cycles[2] - done_cycles[1], 32'd10);
    end
    repeat (12) @(negedge clk);

    // Reset in the 4th RUN cycle of 0x7F+0x7F.
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", {22'd0, busy, done, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    late_dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) late_dones++;
    end
    check("no done after reset", late_dones, 32'd0);
    $display("op reset-abort done/busy seen after reset=%0d", late_dones);
    run_op(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, "post_reset");

    // Randomised operations against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      rexp = model(ra, rb, rs);
      run_op(ra, rb, rs, rexp[7:0], rexp[8], $sformatf("rnd%0d", n));
    end

    // WIDTH=2 exhaustive.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        run_op2(2'(i), 2'(j));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
